// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and helpers for the pipelined MAC datapath and
// the filter output stage.
//   - *_DEF          default widths / shift / depth
//   - sat_max(w)     largest  w-bit two's-complement value, in a 64-bit word
//   - sat_min(w)     smallest w-bit two's-complement value, in a 64-bit word
//   - rnd_const(s)   half-LSB rounding addend for an arithmetic shift by s
// The helpers return 64-bit words, so callers are limited to widths <= 63.
package mac_pkg;

  localparam int A_W_DEF   = 16;
  localparam int B_W_DEF   = 16;
  localparam int ACC_W_DEF = 40;
  localparam int OUT_W_DEF = 16;
  localparam int SHIFT_DEF = 15;
  localparam int PIPE_DEF  = 3;

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

  function automatic logic [63:0] rnd_const(input int shift);
    logic [63:0] r;
    if (shift == 0) r = 64'd0;
    else            r = 64'd1 << (shift - 1);
    return r;
  endfunction

endpackage

// File: rtl/round_sat.sv
// round_sat: combinational round-half-up, arithmetic right shift and
// saturation of a signed accumulator value to a signed output width.
// Ports:
//   acc   in  ACC_W  signed accumulator value
//   data  out OUT_W  rounded, shifted, saturated result
//   sat   out 1      result was clamped to max/min
// SHIFT=0 degenerates to a pure saturation (rounding addend is zero).
module round_sat
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  localparam logic [63:0]    RND64 = rnd_const(SHIFT);
  localparam logic [63:0]    MAX64 = sat_max(OUT_W);
  localparam logic [63:0]    MIN64 = sat_min(OUT_W);
  localparam logic [ACC_W:0] RND   = RND64[ACC_W:0];

  // One guard bit so acc + rounding addend cannot wrap.
  logic signed [ACC_W:0]           sum;
  logic signed [ACC_W:0]           r;
  // Bits from the output sign bit upward; they must all agree for R to fit.
  logic        [ACC_W-OUT_W+1:0]   hi;

  always_comb begin
    sum  = $signed({acc[ACC_W-1], acc}) + $signed(RND);
    r    = sum >>> SHIFT;
    hi   = r[ACC_W:OUT_W-1];
    data = r[OUT_W-1:0];
    sat  = 1'b0;
    if (!((&hi) || !(|hi))) begin
      sat  = 1'b1;
      data = r[ACC_W] ? MIN64[OUT_W-1:0] : MAX64[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/pipelined_mac.sv
// pipelined_mac: pipelined signed multiply / multiply-accumulate with
// valid/ready flow control, round-half-up scaling and output saturation.
// Stage 1 captures operands, stage 2 holds the full product, stages
// 3..PIPE-1 are delay, stage PIPE updates the accumulator and the output
// register. With PIPE=2 the product is formed combinationally in front of
// the final stage. All stages advance together.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready = pipeline advance)
//   a, b                 signed operands
//   acc_en, acc_clr      accumulate / start-of-sum controls for the beat
//   out_valid/out_ready  output handshake
//   out_data, out_sat    result and clamp flag
// ACC_W must be >= A_W+B_W and <= 63; PIPE must be 2..6.
module pipelined_mac
  import mac_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int PIPE  = PIPE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int P_W = A_W + B_W;

  logic                    advance;
  logic [PIPE:1]           vld_q, vld_d;
  logic [PIPE-1:1]         en_q, en_d, clr_q, clr_d;
  logic signed [A_W-1:0]   a_q, a_d;
  logic signed [B_W-1:0]   b_q, b_d;
  logic signed [P_W-1:0]   prod_c, p_fin;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_new;
  logic [OUT_W-1:0]        out_data_q, out_data_d, rs_data;
  logic                    out_sat_q, out_sat_d, rs_sat;

  assign advance   = !vld_q[PIPE] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[PIPE];
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Stage 1 and the valid / control chain.
  always_comb begin
    vld_d = vld_q;
    en_d  = en_q;
    clr_d = clr_q;
    a_d   = a_q;
    b_d   = b_q;
    if (advance) begin
      vld_d[1] = in_valid;
      en_d[1]  = acc_en;
      clr_d[1] = acc_clr;
      a_d      = a;
      b_d      = b;
      for (int k = 2; k <= PIPE; k++) vld_d[k] = vld_q[k-1];
      for (int k = 2; k <= PIPE - 1; k++) begin
        en_d[k]  = en_q[k-1];
        clr_d[k] = clr_q[k-1];
      end
    end
  end

  assign prod_c = $signed({{B_W{a_q[A_W-1]}}, a_q}) *
                  $signed({{A_W{b_q[B_W-1]}}, b_q});

  // Product registers for stages 2..PIPE-1 (none when PIPE=2).
  if (PIPE == 2) begin : g_p_direct
    assign p_fin = prod_c;
  end else begin : g_p_pipe
    logic signed [P_W-1:0] p_q [2:PIPE-1];
    logic signed [P_W-1:0] p_d [2:PIPE-1];

    always_comb begin
      p_d = p_q;
      if (advance) begin
        p_d[2] = prod_c;
        for (int k = 3; k <= PIPE - 1; k++) p_d[k] = p_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 2; k <= PIPE - 1; k++) p_q[k] <= '0;
      end else begin
        p_q <= p_d;
      end
    end

    assign p_fin = p_q[PIPE-1];
  end

  // acc_clr wins over acc_en; a plain multiply also restarts from zero.
  assign acc_new = ((clr_q[PIPE-1] || !en_q[PIPE-1]) ? '0 : acc_q)
                   + ACC_W'(p_fin);

  round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc  (acc_new),
    .data (rs_data),
    .sat  (rs_sat)
  );

  // Final stage: only a valid beat moving in touches acc and the output.
  always_comb begin
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (advance && vld_q[PIPE-1]) begin
      acc_d      = acc_new;
      out_data_d = rs_data;
      out_sat_d  = rs_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      en_q       <= '0;
      clr_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      en_q       <= en_d;
      clr_q      <= clr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_pipelined_mac.sv
// Directed bench for pipelined_mac at default parameters (16x16, ACC 40,
// Q15 scaling, PIPE 3). Inputs change 1 ns after a rising edge; outputs are
// sampled on the falling edge.
module tb_pipelined_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, acc_en, acc_clr;
  logic        out_valid, out_ready, out_sat;
  logic [15:0] a, b, out_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipelined_mac #(
    .A_W(16), .B_W(16), .ACC_W(40), .OUT_W(16), .SHIFT(15), .PIPE(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One beat, accepted on the second rising edge after the call.
  task automatic send(input int va, input int vb, input logic en,
                      input logic clr);
    @(posedge clk); #1;
    a = 16'(va); b = 16'(vb); acc_en = en; acc_clr = clr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for the next output beat and check it.
  task automatic expect_out(input string tag, input int exp_d,
                            input logic exp_s);
    int  n   = 0;
    logic got = 1'b0;
    while (n < 12 && !got) begin
      @(negedge clk);
      n++;
      got = out_valid;
    end
    check({tag, " valid"}, 32'(got), 1);
    if (got) begin
      check({tag, " data"}, 32'($signed(out_data)), exp_d);
      check({tag, " sat"},  32'(out_sat), 32'(exp_s));
    end
  endtask

  initial begin
    int   n, sent, recv, held;
    logic got, stall_prev;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_data",  32'(out_data), 0);
    check("reset out_sat",   32'(out_sat), 0);
    check("reset in_ready",  32'(in_ready), 1);

    // 1: plain Q15 multiply and latency
    send(16384, 16384, 1'b0, 1'b0);
    n = 0; got = 1'b0;
    while (n < 10 && !got) begin
      @(negedge clk);
      n++;
      got = out_valid;
    end
    check("t1 latency", n, 3);
    check("t1 data", 32'($signed(out_data)), 8192);
    check("t1 sat",  32'(out_sat), 0);

    // 2: saturation boundary
    send(-32768, -32768, 1'b0, 1'b0);
    expect_out("t2 minxmin", 32767, 1'b1);
    send(-32768, 32767, 1'b0, 1'b0);
    expect_out("t2 minxmax", -32767, 1'b0);

    // 3: rounding half up
    send(1, 16384, 1'b0, 1'b0);
    expect_out("t3 half pos", 1, 1'b0);
    send(-1, 16384, 1'b0, 1'b0);
    expect_out("t3 half neg", 0, 1'b0);
    send(1, 8191, 1'b0, 1'b0);
    expect_out("t3 below half", 0, 1'b0);

    // 4: running sum, then restart
    send(8192, 8192, 1'b1, 1'b1);
    expect_out("t4 sum0", 2048, 1'b0);
    send(8192, 8192, 1'b1, 1'b0);
    expect_out("t4 sum1", 4096, 1'b0);
    send(8192, 8192, 1'b1, 1'b0);
    expect_out("t4 sum2", 6144, 1'b0);
    send(8192, 8192, 1'b1, 1'b0);
    expect_out("t4 sum3", 8192, 1'b0);
    send(8192, 8192, 1'b1, 1'b1);
    expect_out("t4 restart", 2048, 1'b0);

    // 5: 8-beat stream (beat i yields i), out_ready low for 5 cycles
    sent = 0; recv = 0; held = 0; stall_prev = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (sent < 8);
      a = 16'(2 * (sent + 1)); b = 16'd16384; acc_en = 1'b0; acc_clr = 1'b0;
      @(negedge clk);
      if (out_valid && !out_ready) begin
        check("t5 in_ready stall", 32'(in_ready), 0);
        if (stall_prev) check("t5 hold", 32'($signed(out_data)), held);
        held = $signed(out_data);
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        check("t5 order", 32'($signed(out_data)), recv + 1);
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("t5 sent", sent, 8);
    check("t5 recv", recv, 8);

    // 6: reset with beats in flight, then sum restarts from zero
    send(8192, 8192, 1'b1, 1'b1);
    expect_out("t6 preload", 2048, 1'b0);
    @(posedge clk); #1;
    a = 16'd8192; b = 16'd8192; acc_en = 1'b1; acc_clr = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t6 out_valid after rst", 32'(out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6 no stale", 32'(out_valid), 0);
    end
    send(8192, 8192, 1'b1, 1'b0);
    expect_out("t6 fresh sum", 2048, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_mac.md
Name: pipelined_mac

Overview:
Parametrised, pipelined signed fixed-point multiplier / multiply-accumulator. It is the next generation of the 16x16 combinational product used by the lowpass FIR datapath.
- Adds configurable widths and pipeline depth.
- Adds valid/ready flow control.
- Adds an optional running accumulation for tap summation.
- Adds round-half-up scaling and output saturation.
It sits between the coefficient/sample fetch logic and the filter output register.

Parameters:
A_W, 16, signed width of operand a
B_W, 16, signed width of operand b
ACC_W, 40, accumulator width; must be >= A_W+B_W
OUT_W, 16, signed output width
SHIFT, 15, arithmetic right shift applied before saturation (Q15 default); 0 = no scaling, no rounding
PIPE, 3, cycles from input acceptance to out_valid, stall-free; legal range 2..6

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat present
in_ready  out  1  block can accept a beat this cycle
a  in  A_W  signed operand
b  in  B_W  signed operand
acc_en  in  1  1 = add product to accumulator, 0 = plain multiply
acc_clr  in  1  first beat of a sum; accumulator loads the product instead of adding
out_valid  out  1  output beat present
out_ready  in  1  downstream accepts output
out_data  out  OUT_W  rounded, shifted, saturated result
out_sat  out  1  1 when out_data was clamped (qualified by out_valid)

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; rst sampled high on a clk edge clears state at that edge.
- Reset values: all stage valid bits 0, out_valid 0, out_data 0, out_sat 0, accumulator 0. in_ready is 1 in the cycle after reset.
- Reset mid-operation: all in-flight beats are discarded and nothing is emitted for them. Accumulator contents are lost.
- Pipeline advance: advance = !out_valid || out_ready, and in_ready = advance (combinational). All stages shift together when advance=1 and hold when advance=0. Bubbles propagate as valid=0.
- Acceptance: a beat is accepted when in_valid && in_ready. a, b, acc_en and acc_clr are captured together in stage 1.
- Multiply: stage 2 computes the full-precision signed product P, A_W+B_W bits. Stages 3..PIPE-1 are plain delay registers.
- Final stage (PIPE): the accumulator updates only when a valid beat advances into it.
  - acc_clr=1: acc = sext(P). acc_clr overrides acc_en.
  - acc_en=1, acc_clr=0: acc = acc + sext(P). ACC_W is two's-complement wraparound; no overflow detection inside the accumulator.
  - acc_en=0: acc = sext(P); previous sum is discarded.
- Scaling, applied to the new acc value in the same final stage:
  - SHIFT>0: R = (acc + 2^(SHIFT-1)) >>> SHIFT, round half toward +inf.
  - SHIFT=0: R = acc.
- Saturation:
  - R > 2^(OUT_W-1)-1: out_data = max, out_sat = 1.
  - R < -2^(OUT_W-1): out_data = min, out_sat = 1.
  - Otherwise out_data = R[OUT_W-1:0], out_sat = 0.
- Output: every accepted beat produces exactly one output beat, including intermediate running sums. Stall-free latency = PIPE cycles. Throughput = 1 beat/cycle.
- Backpressure: while out_valid && !out_ready, out_data and out_sat hold stable, in_ready = 0, and the accumulator does not change.
- Simultaneous acceptance of input and output in one cycle is legal and loses nothing.

Decomposition:
- Shared package mac_pkg: default width constants; functions sat_max(w) and sat_min(w); rounding-constant function rnd_const(shift).
- One sub-module, round_sat: combinational round + shift + saturate. Parameters ACC_W, OUT_W, SHIFT; outputs data and sat flag. Reused later by the filter output stage.
- Pipeline registers, valid chain and accumulator stay in pipelined_mac.

Test Plan:
1. Defaults, a=16384, b=16384, acc_en=0 -> out_data=8192, out_sat=0, exactly 3 cycles after acceptance.
2. a=-32768, b=-32768 -> out_data=32767, out_sat=1. a=-32768, b=32767 -> out_data=-32767, out_sat=0.
3. Rounding: a=1, b=16384 -> 1; a=-1, b=16384 -> 0; a=1, b=8191 -> 0.
4. Accumulate: 4 beats of a=8192, b=8192, acc_en=1, acc_clr=1 on beat 0 only -> outputs 2048, 4096, 6144, 8192. A fifth beat with acc_clr=1 -> 2048.
5. Backpressure: continuous input stream, out_ready low for 5 cycles mid-stream -> in_ready low during the stall, out_data stable, no beat lost or duplicated, order preserved.
6. Reset mid-stream: rst high for 1 cycle with 3 beats in flight -> out_valid=0 next cycle, no stale outputs. Following beat with acc_en=1, acc_clr=0 sums from 0.
